// File: rtl/fec_cc_encoder.sv
// Rate-1/2 tail-biting convolutional encoder (K=7, G1=171, G2=133) with ping-pong input banks.
// Define FEC_XY_PAR_EN to emit {X,Y} as one 2-bit beat instead of serial X then Y.
module fec_cc_encoder #(
  parameter int unsigned BLK_LEN = 96,
  parameter int unsigned K       = 7
) (
  input  logic       clk,
  input  logic       reset_N,
  input  logic       data_in,
  input  logic       valid_in,
  output logic       ready_fec,
`ifdef FEC_XY_PAR_EN
  output logic [1:0] data_out,
`else
  output logic       data_out,
`endif
  output logic       valid_out,
  input  logic       ready_in,
  output logic       blk_done
);

  localparam int unsigned PW = $clog2(BLK_LEN);
  localparam int unsigned SW = K - 1;
  localparam logic [PW-1:0] LastIdx = PW'(BLK_LEN - 1);
`ifdef FEC_XY_PAR_EN
  localparam int unsigned DW = 2;
`else
  localparam int unsigned DW = 1;
`endif

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StOutX = 2'd2;
  localparam logic [1:0] StOutY = 2'd3;

  // s[0] is the most recent past bit
  function automatic logic code_x(input logic u, input logic [SW-1:0] s);
    return u ^ s[0] ^ s[1] ^ s[2] ^ s[5];
  endfunction

  function automatic logic code_y(input logic u, input logic [SW-1:0] s);
    return u ^ s[1] ^ s[2] ^ s[4] ^ s[5];
  endfunction

  // First symbol presented for a bit: X alone, or {X,Y} in the parallel build
  function automatic logic [DW-1:0] lead_sym(input logic u, input logic [SW-1:0] s);
`ifdef FEC_XY_PAR_EN
    return {code_x(u, s), code_y(u, s)};
`else
    return code_x(u, s);
`endif
  endfunction

  logic [BLK_LEN-1:0] bank_q [2];
  logic [1:0]         full_q, full_d;
  logic               wbank_q, wbank_d, rbank_q, rbank_d;
  logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d, rptr_inc;
  logic [SW-1:0]      s_q, s_d, s_init, s_shift;
  logic [1:0]         state_q, state_d;
  logic [DW-1:0]      dout_q, dout_d;
  logic               vout_q, vout_d, init_q;
  logic [BLK_LEN-1:0] rword;
  logic               u_cur, u_nxt, wr_en, set_full, accept, beat_done, other_full;

  assign ready_fec = init_q & ~full_q[wbank_q];
  assign wr_en     = valid_in & ready_fec;
  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign accept    = vout_q & ready_in;

`ifdef FEC_XY_PAR_EN
  assign beat_done = accept & (state_q == StOutX);
`else
  assign beat_done = accept & (state_q == StOutY);
`endif

  always_comb begin
    wptr_d   = wptr_q;
    wbank_d  = wbank_q;
    set_full = 1'b0;
    if (wr_en) begin
      if (wptr_q == LastIdx) begin
        wptr_d   = '0;
        wbank_d  = ~wbank_q;
        set_full = 1'b1;
      end else begin
        wptr_d = wptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    rword    = bank_q[rbank_q];
    u_cur    = rword[rptr_q];
    rptr_inc = rptr_q + 1'b1;
    u_nxt    = rword[rptr_inc];
    s_shift  = {s_q[SW-2:0], u_cur};
    for (int i = 0; i < int'(SW); i++) begin
      s_init[i] = rword[BLK_LEN-1-i];
    end
    // A bank completed by the writer this cycle counts as already full
    other_full = full_q[~rbank_q] | (set_full & (wbank_q != rbank_q));

    state_d  = state_q;
    s_d      = s_q;
    rptr_d   = rptr_q;
    rbank_d  = rbank_q;
    dout_d   = dout_q;
    vout_d   = vout_q;
    blk_done = 1'b0;

    case (state_q)
      StIdle: if (full_q[rbank_q]) state_d = StLoad;
      StLoad: begin
        s_d     = s_init;
        rptr_d  = '0;
        dout_d  = lead_sym(rword[0], s_init);
        vout_d  = 1'b1;
        state_d = StOutX;
      end
`ifndef FEC_XY_PAR_EN
      StOutX: begin
        if (accept) begin
          dout_d  = code_y(u_cur, s_q);
          state_d = StOutY;
        end
      end
`endif
      default: ;
    endcase

    if (beat_done) begin
      if (rptr_q == LastIdx) begin
        blk_done = 1'b1;
        vout_d   = 1'b0;
        rbank_d  = ~rbank_q;
        state_d  = other_full ? StLoad : StIdle;
      end else begin
        rptr_d  = rptr_inc;
        s_d     = s_shift;
        dout_d  = lead_sym(u_nxt, s_shift);
        state_d = StOutX;
      end
    end

    full_d = full_q;
    if (blk_done) full_d[rbank_q] = 1'b0;
    if (set_full) full_d[wbank_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      s_q     <= '0;
      state_q <= StIdle;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      s_q     <= s_d;
      state_q <= state_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      init_q  <= 1'b1;
    end
  end

  // Block storage carries no reset; the full flags gate every read
  always_ff @(posedge clk) begin
    if (wr_en) bank_q[wbank_q][wptr_q] <= data_in;
  end

endmodule

// File: doc/fec_cc_encoder.md
Name: fec_cc_encoder

Overview:
- Rate-1/2 tail-biting convolutional encoder for the WiMAX PHY channel-coding chain.
- Sits directly downstream of the PRBS randomizer. It consumes the randomizer's serial bit stream, one 96-bit block at a time.
- Emits 192 coded bits per block, serialized X,Y, to the interleaver.
- Ping-pong buffering lets the next block fill while the current block is being encoded.

Parameters:
- BLK_LEN, 96, input bits per block (tail-biting unit).
- K, 7, constraint length; encoder state is K-1 = 6 bits.

Ports:
- clk  input  1  system clock, rising edge
- reset_N  input  1  asynchronous active-low reset
- data_in  input  1  randomized bit from the PRBS stage
- valid_in  input  1  data_in valid; driven by the PRBS valid_out
- ready_fec  output  1  encoder can accept data_in this cycle; drives the PRBS ready_fec
- data_out  output  1  coded bit to the interleaver
- valid_out  output  1  data_out valid
- ready_in  input  1  interleaver accepts data_out
- blk_done  output  1  one-cycle pulse when the last Y bit of a block is accepted downstream

Behaviour:
- Clock and reset: one clock, clk. Reset reset_N is asynchronous, active-low.
- Reset values:
  - ready_fec=0 during reset, 1 from the first clock edge after release.
  - valid_out=0, data_out=0, blk_done=0.
  - Both banks empty; write pointer 0; write bank 0; FSM in IDLE.
- Reset mid-operation: any partial or full blocks are discarded with no output.
- Input side:
  - A bit is accepted when valid_in && ready_fec at a clk edge.
  - The bit is stored at bank[wbank][wptr]; wptr = 0..95.
  - At wptr==95: mark the bank full, wptr wraps to 0, wbank toggles.
  - ready_fec = !full[wbank].
  - Both banks full → ready_fec=0 until the encoder frees a bank.
- Bit order: u0..u95 in arrival order.
- Encoder state s[5:0], where s0 = most recent past bit.
- Tail-biting initialisation before u0: s0=u95, s1=u94, s2=u93, s3=u92, s4=u91, s5=u90.
- Code outputs per bit k (G1=171 octal, G2=133 octal):
  - X_k = u_k ^ s0 ^ s1 ^ s2 ^ s5.
  - Y_k = u_k ^ s1 ^ s2 ^ s4 ^ s5.
  - After Y_k is accepted: s = {s4..s0, u_k} shifted so that s0 ← u_k.
- FSM:
  - IDLE: wait for full[rbank] → LOAD.
  - LOAD: one cycle; load s from bank[rbank][95:90]; rptr=0 → OUT_X.
  - OUT_X: present X_rptr. On accept → OUT_Y.
  - OUT_Y: present Y_rptr. On accept:
    - rptr<95: rptr++, → OUT_X.
    - rptr==95: clear full[rbank], toggle rbank, pulse blk_done.
      - Other bank already full: → LOAD.
      - Otherwise: → IDLE.
- Latency: u95 accepted at edge T. valid_out=1 with X_0 after edge T+2.
- Output handshake:
  - data_out and valid_out are registered.
  - data_out is held stable while valid_out && !ready_in.
  - valid_out never deasserts within a block without an accept.
  - Sustained throughput at ready_in=1: 192 output cycles plus 1 LOAD cycle per block. Input backpressure via ready_fec is therefore expected.
- Simultaneous events:
  - Freeing full[rbank] and the writer completing the other bank in the same cycle: both take effect.
  - A bank freed this cycle shows ready_fec=1 next cycle.
- Encoding runs only from full banks; no partial-block encoding.

Optional Feature:
- Macro FEC_XY_PAR_EN.
- When defined:
  - data_out widens to 2 bits, {X_k, Y_k} per beat.
  - OUT_X and OUT_Y merge into a single OUT state.
  - 96 beats per block; blk_done pulses on beat 95 accept.
  - Latency is unchanged.
- When undefined: serial 1-bit X,Y order as above.

Test Plan:
- Reset mid-block: assert reset_N=0 after 40 bits → valid_out=0 and ready_fec=0 immediately. A subsequent clean 96-bit all-zero block → 192 zeros, no residue from the aborted block.
- All-ones block, ready_in=1 → 192 ones. valid_out first high two edges after u95 accepted; blk_done single pulse.
- Only u0=1, all other bits 0 → output begins 11 10 11 11 00 01 11, remaining 178 bits 0.
- Tail-biting check, only u95=1 → output begins 10 11 11 00 01 11. Bits 12..189 are 0. Last pair (X95,Y95) = 11.
- Backpressure: ready_in toggled 1/0 every cycle during the u0=1 block → identical bit sequence; data_out held on stall cycles.
- Stream of 3 back-to-back blocks with valid_in=1 continuously:
  - ready_fec drops after 192 input bits (both banks full).
  - It re-rises the cycle after the first blk_done.
  - No bits lost or duplicated: 576 outputs total.
